// File: rtl/afifo_core.sv
// Single-clock FIFO: DEPTH x WIDTH storage, write/full and read/empty handshakes,
// registered read data, flags decoded directly from the registered pointers.
module afifo_core #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wen_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             wfull_o,
    input  logic             ren_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rempty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             wr_accept;
    logic             rd_accept;

    logic [WIDTH-1:0] mem [DEPTH];

    // The extra MSB on each pointer separates "same slot, same lap" (empty)
    // from "same slot, one lap apart" (full).
    assign rempty_o = (wptr_q == rptr_q);
    assign wfull_o  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o  = rdata_q;

    always_comb begin
        // NOTE: every signal gets a default before any condition so the
        // block stays purely combinational and never infers a latch.
        wr_accept = wen_i && !wfull_o && !rst_i;
        rd_accept = ren_i && !rempty_o;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rdata_d   = rdata_q;

        if (wr_accept) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (rd_accept) begin
            rptr_d  = rptr_q + (AW+1)'(1);
            rdata_d = mem[rptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers already
    // discards its contents logically, and leaving it unreset keeps it a RAM.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_afifo_core.sv
// Directed bench for afifo_core: reset, fill/drain boundaries, simultaneous
// access, randomised wrap-around against a reference queue, mid-run reset.
module tb_afifo_core;

    localparam int DEPTH = 256;
    localparam int WIDTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             wen_i;
    logic [WIDTH-1:0] wdata_i;
    logic             wfull_o;
    logic             ren_i;
    logic [WIDTH-1:0] rdata_o;
    logic             rempty_o;

    afifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wen_i    (wen_i),
        .wdata_i  (wdata_i),
        .wfull_o  (wfull_o),
        .ren_i    (ren_i),
        .rdata_o  (rdata_o),
        .rempty_o (rempty_o)
    );

    always #5 clk_i = ~clk_i;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given requests; the reference queue is updated using
    // the occupancy as it stood before the edge.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
        bit was_full;
        bit was_empty;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        wen_i   = w;
        wdata_i = d;
        ren_i   = r;
        @(posedge clk_i);
        #1;
        if (r && !was_empty) exp_rdata = model_q.pop_front();
        if (w && !was_full)  model_q.push_back(d);
        wen_i = 1'b0;
        ren_i = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_empty"}, 32'(rempty_o), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(wfull_o),  32'(model_q.size() == DEPTH));
        check({tag, "_rdata"}, 32'(rdata_o),  32'(exp_rdata));
    endtask

    task automatic async_reset_pulse(input string tag);
        #3;
        rst_i = 1'b1;
        #1;
        check({tag, "_empty"}, 32'(rempty_o), 32'd1);
        check({tag, "_full"},  32'(wfull_o),  32'd0);
        check({tag, "_rdata"}, 32'(rdata_o),  32'd0);
        model_q.delete();
        exp_rdata = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int  written;
        bit  saw_full;
        bit  saw_empty;
        bit  w;
        bit  r;
        int  pw;
        logic [WIDTH-1:0] d;

        rst_i     = 1'b1;
        wen_i     = 1'b0;
        ren_i     = 1'b0;
        wdata_i   = '0;
        exp_rdata = '0;

        // Reset is asynchronous: outputs settle before the first clock edge.
        #2;
        check("por_empty", 32'(rempty_o), 32'd1);
        check("por_full",  32'(wfull_o),  32'd0);
        check("por_rdata", 32'(rdata_o),  32'd0);

        // A write request held across an edge during reset is ignored.
        wen_i   = 1'b1;
        wdata_i = 16'h1234;
        @(posedge clk_i);
        #1;
        wen_i = 1'b0;
        check("rst_ignore_wr", 32'(rempty_o), 32'd1);
        rst_i = 1'b0;

        // Some traffic, then an asynchronous reset between edges.
        cycle(1'b1, 16'h0011, 1'b0);
        check("first_wr_empty", 32'(rempty_o), 32'd0);
        cycle(1'b1, 16'h0022, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1);
        check("pre_rst_rdata", 32'(rdata_o), 32'h11);
        async_reset_pulse("async_rst");

        // Fill to full, then an over-full write must be dropped.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0);
            if (i == 1)         check("fill_first_empty", 32'(rempty_o), 32'd0);
            if (i == DEPTH - 1) check("fill_255_full",    32'(wfull_o),  32'd0);
        end
        check("fill_256_full", 32'(wfull_o), 32'd1);
        cycle(1'b1, 16'd999, 1'b0);
        check("overfill_full", 32'(wfull_o), 32'd1);

        // Drain with one extra read past empty.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
            check("drain_rdata", 32'(rdata_o), (i <= DEPTH) ? 32'(i) : 32'(DEPTH));
            if (i == DEPTH - 1) check("drain_255_empty", 32'(rempty_o), 32'd0);
            if (i >= DEPTH)     check("drain_end_empty", 32'(rempty_o), 32'd1);
        end

        // Steady simultaneous access with 10 words buffered.
        for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'(100 + i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, WIDTH'(200 + k), 1'b1);
            check("sim_rdata", 32'(rdata_o), (k < 10) ? 32'(100 + k) : 32'(200 + k - 10));
            check("sim_empty", 32'(rempty_o), 32'd0);
            check("sim_full",  32'(wfull_o),  32'd0);
        end

        // Simultaneous access when full: only the read happens.
        for (int i = 0; i < DEPTH - 10; i++) cycle(1'b1, WIDTH'(300 + i), 1'b0);
        check("sim_fill_full", 32'(wfull_o), 32'd1);
        cycle(1'b1, 16'hBEEF, 1'b1);
        check("full_rw_full",  32'(wfull_o), 32'd0);
        check("full_rw_rdata", 32'(rdata_o), 32'd210);
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
            check_state("full_drain");
        end
        check("full_drain_empty", 32'(rempty_o), 32'd1);

        // Simultaneous access when empty: only the write happens, no bypass.
        d = rdata_o;
        cycle(1'b1, 16'h7777, 1'b1);
        check("empty_rw_empty", 32'(rempty_o), 32'd0);
        check("empty_rw_rdata", 32'(rdata_o),  32'(d));
        cycle(1'b0, 16'h0000, 1'b1);
        check("empty_rw_read", 32'(rdata_o), 32'h7777);

        // Wrap-around: 3*DEPTH words with alternating fill/drain biased enables.
        written   = 0;
        saw_full  = 1'b0;
        saw_empty = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (written >= 3 * DEPTH && model_q.size() == 0) break;
            pw = ((cyc / 600) % 2 == 0) ? 85 : 25;
            w  = (written < 3 * DEPTH) && ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < (110 - pw));
            d  = WIDTH'($urandom);
            if (w && model_q.size() < DEPTH) written++;
            cycle(w, d, r);
            check_state("wrap");
            saw_full  = saw_full  | wfull_o;
            saw_empty = saw_empty | rempty_o;
        end
        check("wrap_done",      32'(written == 3 * DEPTH && model_q.size() == 0), 32'd1);
        check("wrap_saw_full",  32'(saw_full),  32'd1);
        check("wrap_saw_empty", 32'(saw_empty), 32'd1);

        // Mid-operation reset with 100 words stored.
        for (int i = 0; i < 100; i++) cycle(1'b1, WIDTH'(16'h5000 + i), 1'b0);
        check("pre_mid_rst_empty", 32'(rempty_o), 32'd0);
        async_reset_pulse("mid_rst");
        cycle(1'b1, 16'hA5A5, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1);
        check("post_rst_rdata", 32'(rdata_o),  32'hA5A5);
        check("post_rst_empty", 32'(rempty_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/afifo_core.md
# afifo_core

Single-clock first-in/first-out buffer, DEPTH words of WIDTH bits. Producer logic writes through a write-enable/full handshake and consumer logic reads through a read-enable/empty handshake. Both run on one clock. The block sits between a data source and a sink that run at different instantaneous rates, and absorbs bursts of up to DEPTH words.

## Interface
- DEPTH, default 256: number of storage words; must be a power of two, 2 or greater.
- WIDTH, default 16: data word width in bits.
- AW (local, derived): log2(DEPTH), the address width.

Ports:
- clk_i  input  1  single clock; every register updates on the rising edge.
- rst_i  input  1  reset, asynchronous and active-high; clears pointers and flags immediately.
- wen_i  input  1  write request, sampled on the rising edge of clk_i.
- wdata_i  input  WIDTH  write data, sampled together with wen_i.
- wfull_o  output  1  FIFO holds DEPTH words.
- ren_i  input  1  read request, sampled on the rising edge of clk_i.
- rdata_o  output  WIDTH  read data, registered.
- rempty_o  output  1  FIFO holds 0 words.

## Operation
- Storage: DEPTH x WIDTH memory array; the memory contents are not reset.
- Pointers: the write pointer (wptr) and read pointer (rptr) are each AW+1 bits, binary. The low AW bits address the memory; the MSB is the wrap bit.
- Write acceptance: a write is accepted when wen_i=1 and wfull_o=0.
  - An accepted write stores wdata_i at mem[wptr[AW-1:0]] and increments wptr modulo 2^(AW+1).
  - wen_i=1 while wfull_o=1 is ignored: no storage, no pointer change, no error output.
- Read acceptance: a read is accepted when ren_i=1 and rempty_o=0.
  - An accepted read loads rdata_o with mem[rptr[AW-1:0]] and increments rptr.
  - ren_i=1 while rempty_o=1 is ignored and rdata_o holds its previous value.
- Flags: both are computed from the registered pointers.
  - rempty_o = (wptr == rptr).
  - wfull_o = (wptr[AW] != rptr[AW]) and (wptr[AW-1:0] == rptr[AW-1:0]).
- Simultaneous write and read on the same edge:
  - Each is qualified independently against the flags as they were before that edge.
  - When not full and not empty, both are accepted and occupancy is unchanged.
  - When full, only the read is accepted (the write is dropped).
  - When empty, only the write is accepted (the read is dropped; the written word is not bypassed to rdata_o).
- Ordering: words are read out in exactly the order they were accepted, with no loss or duplication while the handshake rules are obeyed.
- Wrap-around: the address wraps from DEPTH-1 to 0 and toggles the pointer MSB. Operation continues indefinitely.
- Reset (rst_i=1, at any time including mid-transfer):
  - wptr=0, rptr=0, rdata_o=0, rempty_o=1, wfull_o=0, effective immediately without waiting for a clock edge.
  - All stored data is discarded logically.
  - Requests are ignored while rst_i=1.
  - The first edge after rst_i deasserts may accept a write.

## Timing
- Write-to-flag latency: flags reflect an accepted write or read immediately after that rising edge, with no extra cycle.
  - rempty_o falls after the edge of the first write into an empty FIFO.
  - wfull_o rises after the edge of the DEPTH-th outstanding write.
- Read latency: 1 cycle. rdata_o is valid after the rising edge on which the read is accepted, and holds until the next accepted read.
- Write-to-read: a word written on edge N can be read (ren_i accepted) on edge N+1 at the earliest; the data appears on rdata_o after edge N+1.
- Throughput: one write and one read per cycle sustained.
- Flags never glitch between edges, since they are pure functions of the registered pointers.

## Test plan
- Reset values: assert rst_i asynchronously between clock edges -> rempty_o=1, wfull_o=0 and rdata_o=0 immediately, with no clock edge needed.
- Fill to full: write 1,2,...,256 on consecutive edges -> wfull_o=1 after the 256th write. Then drive a 257th write of 999 -> it is ignored and wfull_o stays 1.
- Drain: from full, assert ren_i for 257 cycles -> rdata_o reads 1..256 in order with 1-cycle latency. rempty_o=1 after the 256th read. The 257th read is ignored and rdata_o stays 256.
- Simultaneous access:
  - With 10 words stored, drive wen_i=ren_i=1 for 20 cycles -> occupancy stays 10 and no flag toggles.
  - When full, a simultaneous write+read -> only the read occurs and wfull_o falls.
  - When empty, a simultaneous write+read -> only the write occurs and rempty_o falls.
- Wrap-around: run 3*DEPTH words through with random enable patterns -> the read sequence matches a reference queue exactly, and the flags match the queue's occupancy of 0 (empty) or 256 (full).
- Mid-operation reset: with 100 words stored, pulse rst_i -> rempty_o=1 and wfull_o=0. Then write 0xA5A5 and read it -> rdata_o=0xA5A5 with no stale data returned.
